rca_seq16: RTL and testbench

RCA_SEQ16 -- requirements
Module: rca_seq16

---
 rtl/rca_seq16_if.sv | 27 ++
 rtl/rca_seq16.sv | 154 +++++++++++++++
 tb/tb_rca_seq16.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rca_seq16_if.sv
// Request/result bundle for the sequential ripple-carry adder rca_seq16.
// The optional sub line exists only when RCA_SEQ_SUB_EN is defined.
interface rca_seq16_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         ci;
`ifdef RCA_SEQ_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;

`ifdef RCA_SEQ_SUB_EN
  modport master (output start, x, y, ci, sub, input busy, done, s, co);
  modport slave  (input start, x, y, ci, sub, output busy, done, s, co);
`else
  modport master (output start, x, y, ci, input busy, done, s, co);
  modport slave  (input start, x, y, ci, output busy, done, s, co);
`endif
endinterface

// File: rtl/rca_seq16.sv
// Sequential adder: one 4-bit ripple-carry slice reused over NIBBLES cycles, LSB nibble first.
// Optional RCA_SEQ_SUB_EN adds a sub request that computes x - y (co=1 means no borrow).

// 4-bit ripple-carry slice built from full-adder bits
module rca_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end
endmodule

module rca_seq16 #(
  parameter int unsigned NIBBLES = 4  // legal range 2..8
) (
  input  logic        clk,
  input  logic        rst,
  rca_seq16_if.slave  bus
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic          c, c_n;
  logic [W-1:0]  xr, xr_n;
  logic [W-1:0]  yr, yr_n;
  logic [W-1:0]  s_q, s_n;
  logic          co_q, co_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;

  logic [3:0]    sl_x, sl_y, sl_sum;
  logic          sl_co;

  rca_4bit u_slice (
    .a    (sl_x),
    .b    (sl_y),
    .cin  (c),
    .sum  (sl_sum),
    .cout (sl_co)
  );

  // Slice operand select by constant-index loop keeps widths exact
  always_comb begin
    sl_x = '0;
    sl_y = '0;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (idx == IW'(i)) begin
        sl_x = xr[4*i +: 4];
        sl_y = yr[4*i +: 4];
      end
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_n = state;
    idx_n   = idx;
    c_n     = c;
    xr_n    = xr;
    yr_n    = yr;
    s_n     = s_q;
    co_n    = co_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          xr_n  = bus.x;
`ifdef RCA_SEQ_SUB_EN
          yr_n  = bus.sub ? ~bus.y : bus.y;
          c_n   = bus.sub | bus.ci;
`else
          yr_n  = bus.y;
          c_n   = bus.ci;
`endif
          idx_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < int'(NIBBLES); i++) begin
          if (idx == IW'(i)) begin
            s_n[4*i +: 4] = sl_sum;
          end
        end
        c_n = sl_co;
        if (idx == IW'(NIBBLES - 1)) begin
          co_n    = sl_co;
          state_n = DONE;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  // State and datapath registers; reset wins over any request
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      c      <= 1'b0;
      xr     <= '0;
      yr     <= '0;
      s_q    <= '0;
      co_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      c      <= c_n;
      xr     <= xr_n;
      yr     <= yr_n;
      s_q    <= s_n;
      co_q   <= co_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_rca_seq16.sv
// Directed bench for rca_seq16 (NIBBLES=4): latency, carry boundaries, ignored starts, reset abort.
module tb_rca_seq16;
  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic sub_val = 1'b0;

  always #5 clk = ~clk;

  rca_seq16_if #(.NIBBLES(NIBBLES)) bus ();

  rca_seq16 #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Pulse start for one edge, then scramble operands to prove they are not re-read
  task automatic drive_start(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic civ);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = xv;
    bus.y     = yv;
    bus.ci    = civ;
`ifdef RCA_SEQ_SUB_EN
    bus.sub   = sub_val;
`endif
    @(negedge clk);
    bus.start = 1'b0;
    bus.x     = 16'hDEAD;
    bus.y     = 16'hBEEF;
    bus.ci    = ~civ;
`ifdef RCA_SEQ_SUB_EN
    bus.sub   = ~sub_val;
`endif
  endtask

  // Observe a fixed 12-cycle window: first done cycle (0 = none) and pulse count
  task automatic wait_done(output int first, output int pulses);
    first  = 0;
    pulses = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        pulses++;
        if (first == 0) first = n;
      end
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.x     = 16'h1111;
    bus.y     = 16'h2222;
    bus.ci    = 1'b1;
`ifdef RCA_SEQ_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b expected=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done actual=%b expected=0", bus.done); end
    checks++; if (bus.s !== 16'h0000) begin errors++; $display("FAIL reset_s actual=%h expected=0000", bus.s); end
    checks++; if (bus.co !== 1'b0) begin errors++; $display("FAIL reset_co actual=%b expected=0", bus.co); end
    bus.start = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic test_carry_boundary;
    int first, pulses;
    drive_start(16'h7FFF, 16'h0001, 1'b0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL cb1_busy actual=%b expected=1", bus.busy); end
    wait_done(first, pulses);
    checks++; if (first != 4) begin errors++; $display("FAIL cb1_latency actual=%0d expected=4", first); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL cb1_pulses actual=%0d expected=1", pulses); end
    checks++; if (bus.s !== 16'h8000) begin errors++; $display("FAIL cb1_s actual=%h expected=8000", bus.s); end
    checks++; if (bus.co !== 1'b0) begin errors++; $display("FAIL cb1_co actual=%b expected=0", bus.co); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cb1_idle_busy actual=%b expected=0", bus.busy); end

    drive_start(16'hFFFF, 16'h0001, 1'b0);
    wait_done(first, pulses);
    checks++; if (first != 4) begin errors++; $display("FAIL cb2_latency actual=%0d expected=4", first); end
    checks++; if (bus.s !== 16'h0000) begin errors++; $display("FAIL cb2_s actual=%h expected=0000", bus.s); end
    checks++; if (bus.co !== 1'b1) begin errors++; $display("FAIL cb2_co actual=%b expected=1", bus.co); end
  endtask

  // Extra starts during RUN and DONE must be ignored: one pulse, unchanged result
  task automatic test_ignored_start;
    int first, pulses;
    drive_start(16'h1234, 16'h4321, 1'b1);
    first  = 0;
    pulses = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        pulses++;
        if (first == 0) first = n;
      end
      bus.start = (n == 1 || n == 2 || n == 4) ? 1'b1 : 1'b0;
    end
    bus.start = 1'b0;
    checks++; if (first != 4) begin errors++; $display("FAIL ign_latency actual=%0d expected=4", first); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL ign_pulses actual=%0d expected=1", pulses); end
    checks++; if (bus.s !== 16'h5556) begin errors++; $display("FAIL ign_s actual=%h expected=5556", bus.s); end
    checks++; if (bus.co !== 1'b0) begin errors++; $display("FAIL ign_co actual=%b expected=0", bus.co); end
  endtask

  task automatic test_back_to_back;
    int first, pulses;
    drive_start(16'hFFFF, 16'hFFFF, 1'b1);
    wait_done(first, pulses);
    checks++; if (bus.s !== 16'hFFFF) begin errors++; $display("FAIL b2b1_s actual=%h expected=FFFF", bus.s); end
    checks++; if (bus.co !== 1'b1) begin errors++; $display("FAIL b2b1_co actual=%b expected=1", bus.co); end
    drive_start(16'h0000, 16'h0000, 1'b0);
    wait_done(first, pulses);
    checks++; if (first != 4) begin errors++; $display("FAIL b2b2_latency actual=%0d expected=4", first); end
    checks++; if (bus.s !== 16'h0000) begin errors++; $display("FAIL b2b2_s actual=%h expected=0000", bus.s); end
    checks++; if (bus.co !== 1'b0) begin errors++; $display("FAIL b2b2_co actual=%b expected=0", bus.co); end
  endtask

  task automatic test_reset_abort;
    int first, pulses;
    drive_start(16'hABCD, 16'h1357, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy actual=%b expected=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done actual=%b expected=0", bus.done); end
    checks++; if (bus.s !== 16'h0000) begin errors++; $display("FAIL abort_s actual=%h expected=0000", bus.s); end
    checks++; if (bus.co !== 1'b0) begin errors++; $display("FAIL abort_co actual=%b expected=0", bus.co); end
    // Start in the very first cycle after reset release
    bus.start = 1'b1;
    bus.x     = 16'h0006;
    bus.y     = 16'h0009;
    bus.ci    = 1'b1;
`ifdef RCA_SEQ_SUB_EN
    bus.sub   = 1'b0;
`endif
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(first, pulses);
    checks++; if (first != 4) begin errors++; $display("FAIL abort_new_latency actual=%0d expected=4", first); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL abort_new_pulses actual=%0d expected=1", pulses); end
    checks++; if (bus.s !== 16'h0010) begin errors++; $display("FAIL abort_new_s actual=%h expected=0010", bus.s); end
    checks++; if (bus.co !== 1'b0) begin errors++; $display("FAIL abort_new_co actual=%b expected=0", bus.co); end
  endtask

`ifdef RCA_SEQ_SUB_EN
  task automatic test_sub;
    int first, pulses;
    sub_val = 1'b1;
    drive_start(16'h0005, 16'h0007, 1'b0);
    wait_done(first, pulses);
    checks++; if (bus.s !== 16'hFFFE) begin errors++; $display("FAIL sub1_s actual=%h expected=FFFE", bus.s); end
    checks++; if (bus.co !== 1'b0) begin errors++; $display("FAIL sub1_co actual=%b expected=0", bus.co); end
    drive_start(16'h0007, 16'h0005, 1'b0);
    wait_done(first, pulses);
    checks++; if (bus.s !== 16'h0002) begin errors++; $display("FAIL sub2_s actual=%h expected=0002", bus.s); end
    checks++; if (bus.co !== 1'b1) begin errors++; $display("FAIL sub2_co actual=%b expected=1", bus.co); end
    sub_val = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_carry_boundary();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
`ifdef RCA_SEQ_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
